// File: rtl/serdes_pkg.sv
// Types and conventions shared by the p2s/s2p serdes pair.
// Both blocks use the same state encoding and bit ordering.
package serdes_pkg;

    typedef enum logic {
        RX = 1'b0,
        TX = 1'b1
    } e_serdes_state;

    // Serial streams carry the word LSB first on both sides of the link.
    localparam bit SERDES_LSB_FIRST = 1'b1;

endpackage

// File: rtl/s2p_if.sv
// Serial-in / parallel-out handshake bundle for the s2p deserializer.
// The slave modport is the deserializer's view; master is the environment's.
interface s2p_if #(
    parameter int unsigned N = 8
);

    logic         s_valid;
    logic         s_data;
    logic         s_ready;
    logic [N-1:0] p_data;
    logic         p_valid;
    logic         p_ready;

    modport slave (
        input  s_valid,
        input  s_data,
        input  p_ready,
        output s_ready,
        output p_data,
        output p_valid
    );

    modport master (
        output s_valid,
        output s_data,
        output p_ready,
        input  s_ready,
        input  p_data,
        input  p_valid
    );

endinterface

// File: rtl/s2p.sv
// Serial-to-parallel deserializer: gathers N bits LSB first, then presents the
// word on a valid/ready port. Handshake outputs decode from state only.
module s2p
    import serdes_pkg::*;
#(
    parameter int unsigned N  = 8,
    localparam int unsigned CW = $clog2(N)
) (
    input logic  clk,
    input logic  rstn,
    s2p_if.slave bus
);

    e_serdes_state state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  shift_q, shift_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RX;
            count_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        unique case (state_q)
            RX: begin
                if (bus.s_valid) begin
                    // New bit enters at the MSB so the first bit ends up at bit 0.
                    shift_d = {bus.s_data, shift_q[N-1:1]};
                    if (count_q == CW'(N - 1)) begin
                        count_d = '0;
                        state_d = TX;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            TX: begin
                if (bus.p_ready) begin
                    state_d = RX;
                end
            end
            default: state_d = RX;
        endcase
    end

    assign bus.s_ready = (state_q == RX);
    assign bus.p_valid = (state_q == TX);
    assign bus.p_data  = shift_q;

`ifndef SYNTHESIS
    a_p_data_stable: assert property (
        @(posedge clk) disable iff (!rstn)
        (bus.p_valid && !bus.p_ready) |=> $stable(bus.p_data)
    );

    a_count_range: assert property (
        @(posedge clk) disable iff (!rstn)
        32'(count_q) < N
    );
`endif

endmodule
